// File: rtl/ensamblador_numeros.sv
// ensamblador_numeros: assembles a stream of digit strobes into an unsigned
// number (Horner's rule), delivering it with a one-cycle done pulse on fin.
//
// Parameters:
//   WIDTH      result width in bits (8..64)
//   MAX_DIGITS max digits accumulated per number (1..20)
//   RADIX      digit base (2..16)
// Build option:
//   ENSAMBLADOR_ASCII_EN  defined: dato is an ASCII character ('0'-'9',
//                         'A'-'F', 'a'-'f'); undefined: dato is the binary
//                         digit value.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-low reset
//   dato       incoming digit, qualified by num_ready
//   num_ready  one-cycle strobe: dato holds a digit
//   fin        one-cycle strobe: number complete
//   resultado  assembled value (registered, held until next delivery)
//   done       one-cycle pulse: resultado and flags valid
//   ndigitos   digits accepted into the delivered result
//   overflow   delivered result saturated
//   error      delivered number had an invalid or excess digit
//   busy       delivering/clearing; num_ready and fin are ignored
module ensamblador_numeros #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 10,
    parameter int RADIX      = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           dato,
    input  logic                                 num_ready,
    input  logic                                 fin,
    output logic [WIDTH-1:0]                     resultado,
    output logic                                 done,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      ndigitos,
    output logic                                 overflow,
    output logic                                 error,
    output logic                                 busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    // Horner product headroom: acc*16 + 15 always fits in WIDTH+5 bits.
    localparam int EW = WIDTH + 5;

    localparam logic [EW-1:0] RADIX_W  = EW'(RADIX);
    localparam logic [7:0]    RADIX_B  = 8'(RADIX);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DIGITS);

    typedef enum logic [1:0] {
        S_ACUM,
        S_SALIDA,
        S_LIMPIA
    } estado_t;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    nd_q, nd_d;
    logic             ovo_q, ovo_d;
    logic             ero_q, ero_d;
    logic             done_q, done_d;

    // Decoded digit value; any undecodable byte maps to 8'hFF, which is
    // always >= RADIX and therefore rejected below.
    logic [7:0]       dval;
    logic             dig_ok;
    logic [EW-1:0]    prod;
    logic             prod_ovf;

`ifdef ENSAMBLADOR_ASCII_EN
    always_comb begin
        dval = 8'hFF;
        unique case (1'b1)
            (dato >= 8'h30 && dato <= 8'h39): dval = dato - 8'h30;
            (dato >= 8'h41 && dato <= 8'h46): dval = dato - 8'h37;
            (dato >= 8'h61 && dato <= 8'h66): dval = dato - 8'h57;
            default:                          dval = 8'hFF;
        endcase
    end
`else
    always_comb begin
        dval = dato;
    end
`endif

    assign dig_ok   = (dval < RADIX_B);
    assign prod     = EW'(acc_q) * RADIX_W + EW'(dval);
    assign prod_ovf = |prod[EW-1:WIDTH];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        res_d   = res_q;
        nd_d    = nd_q;
        ovo_d   = ovo_q;
        ero_d   = ero_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_ACUM: begin
                // The digit is taken before fin so a coincident digit is
                // part of the number being closed.
                if (num_ready) begin
                    if (!dig_ok || cnt_q == MAX_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        // Once saturated, acc stays all ones.
                        if (ovf_q || prod_ovf) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = prod[WIDTH-1:0];
                        end
                    end
                end
                if (fin) begin
                    state_d = S_SALIDA;
                end
            end
            S_SALIDA: begin
                res_d   = acc_q;
                nd_d    = cnt_q;
                ovo_d   = ovf_q;
                ero_d   = err_q;
                done_d  = 1'b1;
                state_d = S_LIMPIA;
            end
            S_LIMPIA: begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                state_d = S_ACUM;
            end
            default: begin
                state_d = S_ACUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_ACUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            nd_q    <= '0;
            ovo_q   <= 1'b0;
            ero_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            res_q   <= res_d;
            nd_q    <= nd_d;
            ovo_q   <= ovo_d;
            ero_q   <= ero_d;
            done_q  <= done_d;
        end
    end

    assign resultado = res_q;
    assign ndigitos  = nd_q;
    assign overflow  = ovo_q;
    assign error     = ero_q;
    assign done      = done_q;
    assign busy      = (state_q != S_ACUM);

endmodule

// File: tb/tb_ensamblador_numeros.sv
// Bench for ensamblador_numeros: four parameterisations share one stimulus
// stream; a digit-list model predicts every output on every cycle.
module tb_ensamblador_numeros;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dato;
    logic       num_ready;
    logic       fin;

    logic [31:0] r0, r2, r3;
    logic [7:0]  r1;
    logic [3:0]  n0, n1, n3;
    logic [1:0]  n2;
    logic [N-1:0] dn, bs, ov, er;

    logic [63:0] ar [N];
    logic [7:0]  an [N];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ensamblador_numeros #(.WIDTH(32), .MAX_DIGITS(10), .RADIX(10)) u0 (
        .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready),
        .fin(fin), .resultado(r0), .done(dn[0]), .ndigitos(n0),
        .overflow(ov[0]), .error(er[0]), .busy(bs[0]));
    ensamblador_numeros #(.WIDTH(8), .MAX_DIGITS(10), .RADIX(10)) u1 (
        .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready),
        .fin(fin), .resultado(r1), .done(dn[1]), .ndigitos(n1),
        .overflow(ov[1]), .error(er[1]), .busy(bs[1]));
    ensamblador_numeros #(.WIDTH(32), .MAX_DIGITS(2), .RADIX(10)) u2 (
        .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready),
        .fin(fin), .resultado(r2), .done(dn[2]), .ndigitos(n2),
        .overflow(ov[2]), .error(er[2]), .busy(bs[2]));
    ensamblador_numeros #(.WIDTH(32), .MAX_DIGITS(10), .RADIX(16)) u3 (
        .clk(clk), .reset(reset), .dato(dato), .num_ready(num_ready),
        .fin(fin), .resultado(r3), .done(dn[3]), .ndigitos(n3),
        .overflow(ov[3]), .error(er[3]), .busy(bs[3]));

    assign ar[0] = {32'd0, r0};
    assign ar[1] = {56'd0, r1};
    assign ar[2] = {32'd0, r2};
    assign ar[3] = {32'd0, r3};
    assign an[0] = {4'd0, n0};
    assign an[1] = {4'd0, n1};
    assign an[2] = {6'd0, n2};
    assign an[3] = {4'd0, n3};

    function automatic int pw(input int k);
        return (k == 1) ? 8 : 32;
    endfunction
    function automatic int pm(input int k);
        return (k == 2) ? 2 : 10;
    endfunction
    function automatic int pr(input int k);
        return (k == 3) ? 16 : 10;
    endfunction

    // Digit value of a byte; 99 marks a byte that is no digit at all.
    function automatic int dec(input logic [7:0] b);
`ifdef ENSAMBLADOR_ASCII_EN
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
        return 99;
`else
        return int'(b);
`endif
    endfunction

    // Byte that carries digit value v (0..15).
    function automatic logic [7:0] enc(input int v);
`ifdef ENSAMBLADOR_ASCII_EN
        if (v < 10) return 8'(48 + v);
        return ($urandom_range(1) == 1) ? 8'(55 + v) : 8'(87 + v);
`else
        return 8'(v);
`endif
    endfunction

    // Model: accepted digits kept as a list; value folded at delivery.
    int              m_bz  [N];
    int              m_n   [N];
    int              m_dg  [N][32];
    bit              m_err [N];
    longint unsigned e_res [N];
    int              e_nd  [N];
    bit              e_ovf [N];
    bit              e_err [N];
    bit              e_done[N];
    bit              e_busy[N];

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                if (!reset) begin
                    m_bz[k]   = 0;
                    m_n[k]    = 0;
                    m_err[k]  = 1'b0;
                    e_res[k]  = 0;
                    e_nd[k]   = 0;
                    e_ovf[k]  = 1'b0;
                    e_err[k]  = 1'b0;
                    e_done[k] = 1'b0;
                end else begin
                    e_done[k] = 1'b0;
                    if (m_bz[k] == 2) begin
                        longint unsigned v, t, mx;
                        bit o;
                        v  = 0;
                        o  = 1'b0;
                        mx = (64'd1 << pw(k)) - 64'd1;
                        for (int i = 0; i < m_n[k]; i++) begin
                            if (!o) begin
                                t = v * longint'(pr(k)) + longint'(m_dg[k][i]);
                                if (t > mx) begin
                                    o = 1'b1;
                                    v = mx;
                                end else begin
                                    v = t;
                                end
                            end
                        end
                        e_res[k]  = v;
                        e_nd[k]   = m_n[k];
                        e_ovf[k]  = o;
                        e_err[k]  = m_err[k];
                        e_done[k] = 1'b1;
                        m_bz[k]   = 1;
                    end else if (m_bz[k] == 1) begin
                        m_n[k]   = 0;
                        m_err[k] = 1'b0;
                        m_bz[k]  = 0;
                    end else begin
                        if (num_ready) begin
                            int d;
                            d = dec(dato);
                            if (d >= pr(k) || m_n[k] == pm(k)) begin
                                m_err[k] = 1'b1;
                            end else begin
                                m_dg[k][m_n[k]] = d;
                                m_n[k]++;
                            end
                        end
                        if (fin) m_bz[k] = 2;
                    end
                end
                e_busy[k] = (m_bz[k] != 0);
            end
        end
    end

    task automatic chk(input string nm, input int k,
                       input longint unsigned a, input longint unsigned e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s[u%0d] t=%0t got %0d expected %0d",
                     nm, k, $time, a, e);
        end
    endtask

    task automatic lit(input string nm,
                       input longint unsigned a, input longint unsigned e);
        chk(nm, 9, a, e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < N; k++) begin
                    chk("resultado", k, ar[k], e_res[k]);
                    chk("ndigitos", k, 64'(an[k]), longint'(e_nd[k]));
                    chk("overflow", k, 64'(ov[k]), 64'(e_ovf[k]));
                    chk("error", k, 64'(er[k]), 64'(e_err[k]));
                    chk("done", k, 64'(dn[k]), 64'(e_done[k]));
                    chk("busy", k, 64'(bs[k]), 64'(e_busy[k]));
                end
            end
        end
    end

    task automatic step(input bit nr, input logic [7:0] d, input bit f);
        num_ready = nr;
        dato      = d;
        fin       = f;
        @(negedge clk);
        num_ready = 1'b0;
        fin       = 1'b0;
    endtask

    // Strobe fin, then stop on the cycle where done is high.
    task automatic deliver();
        step(1'b0, 8'd0, 1'b1);
        @(negedge clk);
    endtask

    logic [7:0] bad;

    initial begin
        reset     = 1'b0;
        dato      = 8'd0;
        num_ready = 1'b0;
        fin       = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        lit("rst_res", ar[0], 0);
        lit("rst_busy", 64'(bs[0]), 0);
        lit("rst_done", 64'(dn[0]), 0);

        // 1,2,3
        step(1'b1, enc(1), 1'b0);
        step(1'b1, enc(2), 1'b0);
        step(1'b1, enc(3), 1'b0);
        step(1'b0, 8'd0, 1'b1);
        lit("done_early", 64'(dn[0]), 0);
        lit("busy_after_fin", 64'(bs[0]), 1);
        @(negedge clk);
        lit("res123", ar[0], 123);
        lit("nd123", 64'(an[0]), 3);
        lit("done123", 64'(dn[0]), 1);
        lit("ovf123", 64'(ov[0]), 0);
        lit("err123", 64'(er[0]), 0);
        @(negedge clk);
        lit("done_one_cycle", 64'(dn[0]), 0);
        lit("hold123", ar[0], 123);

        // 2,5,6 saturates the 8-bit instance
        step(1'b1, enc(2), 1'b0);
        step(1'b1, enc(5), 1'b0);
        step(1'b1, enc(6), 1'b0);
        deliver();
        lit("sat_res", ar[1], 255);
        lit("sat_ovf", 64'(ov[1]), 1);
        lit("wide256", ar[0], 256);
        @(negedge clk);
        step(1'b1, enc(7), 1'b0);
        deliver();
        lit("after_sat_res", ar[1], 7);
        lit("after_sat_ovf", 64'(ov[1]), 0);
        @(negedge clk);

        // 4,12,7: 12 is no radix-10 digit
        step(1'b1, enc(4), 1'b0);
        step(1'b1, enc(12), 1'b0);
        step(1'b1, enc(7), 1'b0);
        deliver();
        lit("inv_res", ar[0], 47);
        lit("inv_err", 64'(er[0]), 1);
        lit("inv_nd", 64'(an[0]), 2);
        @(negedge clk);

        // 1,2,3 into the two-digit instance
        step(1'b1, enc(1), 1'b0);
        step(1'b1, enc(2), 1'b0);
        step(1'b1, enc(3), 1'b0);
        deliver();
        lit("max_res", ar[2], 12);
        lit("max_err", 64'(er[2]), 1);
        lit("max_nd", 64'(an[2]), 2);
        @(negedge clk);

        // 9, then 8 with fin; strobes while busy are dropped
        step(1'b1, enc(9), 1'b0);
        step(1'b1, enc(8), 1'b1);
        step(1'b1, enc(5), 1'b0);
        lit("coinc_res", ar[0], 98);
        lit("coinc_done", 64'(dn[0]), 1);
        step(1'b1, enc(6), 1'b1);
        lit("busy_ign_busy", 64'(bs[0]), 0);
        deliver();
        lit("empty_res", ar[0], 0);
        lit("empty_nd", 64'(an[0]), 0);
        lit("empty_err", 64'(er[0]), 0);
        lit("empty_done", 64'(dn[0]), 1);
        @(negedge clk);

        // reset mid-number
        step(1'b1, enc(5), 1'b0);
        step(1'b1, enc(6), 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        lit("mid_rst_res", ar[0], 0);
        lit("mid_rst_nd", 64'(an[0]), 0);
        lit("mid_rst_busy", 64'(bs[0]), 0);
        lit("mid_rst_done", 64'(dn[0]), 0);
        step(1'b1, enc(7), 1'b0);
        lit("no_done_pre_fin", 64'(dn[0]), 0);
        deliver();
        lit("post_rst_res", ar[0], 7);
        lit("post_rst_nd", 64'(an[0]), 1);
        @(negedge clk);

        // hex digits '1','a','F', then a non-digit byte
`ifdef ENSAMBLADOR_ASCII_EN
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h46, 1'b0);
        bad = 8'h47;
`else
        step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd10, 1'b0);
        step(1'b1, 8'd15, 1'b0);
        bad = 8'd16;
`endif
        deliver();
        lit("hex_res", ar[3], 431);
        lit("hex_err", 64'(er[3]), 0);
        @(negedge clk);
        step(1'b1, enc(1), 1'b0);
        step(1'b1, bad, 1'b0);
        step(1'b1, enc(2), 1'b0);
        deliver();
        lit("hex_bad_res", ar[3], 18);
        lit("hex_bad_err", 64'(er[3]), 1);
        @(negedge clk);

        // random streams: short numbers, then long ones
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2500; c++) begin
                int v;
                reset     = ($urandom_range(199) != 0);
                num_ready = ($urandom_range(2) != 0);
                v         = int'($urandom_range(19));
                dato      = (v < 16) ? enc(v) : 8'($urandom_range(255));
                fin       = (ph == 0) ? ($urandom_range(7) == 0)
                                      : ($urandom_range(24) == 0);
                @(negedge clk);
            end
        end
        reset     = 1'b1;
        num_ready = 1'b0;
        fin       = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
